imm_extend_unit: RTL and testbench

Parametrised, pipelined successor to the datapath's combinational immediate extender. Accepts a 12-bit immediate field plus an extension mode over a valid/ready handshake and produces a registered DATA_W-bit immediate. Adds zero-extend-8 mode, a PREFIX mode that latches upper immediate bits for the following instruction, an error flag for illegal modes, and flush. Sits between decode and the ID/EX register.

---
 rtl/imm_extend_unit.sv | 125 ++++++++++++
 tb/tb_imm_extend_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_unit.sv
// imm_extend_unit: registered immediate extender between decode and ID/EX.
// Takes a 12-bit immediate field and an extension mode over valid/ready.
// Produces a DATA_W-bit immediate one cycle after the input is accepted.
// Mode 5 (PREFIX) latches upper bits that the next instruction uses.
// Modes 6 and 7 are illegal: they produce a zero immediate with out_err set.
module imm_extend_unit #(
    parameter int DATA_W  = 16,
    parameter int FIELD_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FIELD_W-1:0] imm_field,
    input  logic [2:0]        inst_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_err,
    output logic              pfx_pending
);

    // The prefix supplies every result bit except the low nibble.
    localparam int PFX_W = DATA_W - 4;

    localparam logic [0:0] NOPFX = 1'b0;
    localparam logic [0:0] PFX   = 1'b1;

    localparam logic [2:0] MODE_ZX4  = 3'd0;
    localparam logic [2:0] MODE_SX4  = 3'd1;
    localparam logic [2:0] MODE_SX8  = 3'd2;
    localparam logic [2:0] MODE_SX12 = 3'd3;
    localparam logic [2:0] MODE_ZX8  = 3'd4;
    localparam logic [2:0] MODE_PFX  = 3'd5;

    logic [0:0]               state;
    logic signed [PFX_W-1:0]  pfx_reg;
    logic signed [DATA_W-1:0] imm_p1;
    logic                     vld_p1;
    logic                     err_p1;
    logic                     accept;
    logic                     illegal;

    // Standard (no-prefix) extension selected by the mode.
    function automatic logic signed [DATA_W-1:0] extend_imm(
        input logic [11:0] f,
        input logic [2:0]  mode
    );
        logic signed [3:0]        s4;
        logic signed [7:0]        s8;
        logic signed [11:0]       s12;
        logic signed [DATA_W-1:0] r;
        s4  = f[3:0];
        s8  = f[7:0];
        s12 = f;
        case (mode)
            MODE_ZX4:  r = DATA_W'(f[7:4]);
            MODE_SX4:  r = DATA_W'(s4);
            MODE_SX8:  r = DATA_W'(s8);
            MODE_SX12: r = DATA_W'(s12);
            MODE_ZX8:  r = DATA_W'(f[7:0]);
            default:   r = '0;
        endcase
        return r;
    endfunction

    // Prefix field sign-extended to the upper-bits width.
    function automatic logic signed [PFX_W-1:0] extend_prefix(input logic [11:0] f);
        logic signed [11:0] s;
        s = f;
        return PFX_W'(s);
    endfunction

    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;
    assign illegal     = (inst_mode == 3'd6) || (inst_mode == 3'd7);
    assign pfx_pending = (state == PFX);
    assign out_valid   = vld_p1;
    assign out_err     = err_p1;
    assign out_imm     = imm_p1;

    // Control: prefix state, output valid and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= NOPFX;
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
        end else if (flush) begin
            state  <= NOPFX;
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
        end else if (accept) begin
            if (inst_mode == MODE_PFX) begin
                state  <= PFX;
                vld_p1 <= 1'b0;
            end else begin
                state  <= NOPFX;
                vld_p1 <= 1'b1;
                err_p1 <= illegal;
            end
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    // Data: prefix bits and output immediate (p0 -> p1 stage boundary).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pfx_reg <= '0;
            imm_p1  <= '0;
        end else if (!flush && accept) begin
            if (inst_mode == MODE_PFX) begin
                pfx_reg <= extend_prefix(imm_field);
            end else if (illegal) begin
                imm_p1 <= '0;
            end else if (state == PFX) begin
                imm_p1 <= {pfx_reg, imm_field[3:0]};
            end else begin
                imm_p1 <= extend_imm(imm_field, inst_mode);
            end
        end
    end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed testbench for imm_extend_unit with DATA_W = 16.
module tb_imm_extend_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] imm_field;
    logic [2:0]  inst_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_imm;
    logic        out_err;
    logic        pfx_pending;

    int tests;
    int fails;

    imm_extend_unit #(.DATA_W(16), .FIELD_W(12)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .imm_field   (imm_field),
        .inst_mode   (inst_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_err     (out_err),
        .pfx_pending (pfx_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [11:0] f, input logic [2:0] m);
        in_valid  = v;
        imm_field = f;
        inst_mode = m;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 12'h000, 3'd0);
        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_imm", out_imm, 16'h0000);
        check("rst_out_err", out_err, 0);
        check("rst_pfx", pfx_pending, 0);
        rst = 1'b0;

        // Plain extension modes
        drive(1'b1, 12'h0F8, 3'd2); tick();
        check("sx8_valid", out_valid, 1);
        check("sx8_imm", out_imm, 16'hFFF8);
        check("sx8_err", out_err, 0);
        drive(1'b1, 12'hA5C, 3'd0); tick();
        check("zx4_imm", out_imm, 16'h0005);
        drive(1'b1, 12'h0F8, 3'd4); tick();
        check("zx8_imm", out_imm, 16'h00F8);
        drive(1'b1, 12'h800, 3'd3); tick();
        check("sx12_imm", out_imm, 16'hF800);
        check("sx12_valid", out_valid, 1);

        // Prefix then two uses
        drive(1'b1, 12'h123, 3'd5); tick();
        check("pfx_no_valid", out_valid, 0);
        check("pfx_pending", pfx_pending, 1);
        drive(1'b1, 12'h007, 3'd1); tick();
        check("pfx_use_imm", out_imm, 16'h1237);
        check("pfx_use_valid", out_valid, 1);
        check("pfx_use_clear", pfx_pending, 0);
        drive(1'b1, 12'h00F, 3'd1); tick();
        check("after_pfx_imm", out_imm, 16'hFFFF);

        // Double prefix: second overwrites first
        drive(1'b1, 12'h111, 3'd5); tick();
        drive(1'b1, 12'h0AB, 3'd5); tick();
        check("dpfx_pending", pfx_pending, 1);
        check("dpfx_no_valid", out_valid, 0);
        drive(1'b1, 12'h0C5, 3'd2); tick();
        check("dpfx_imm", out_imm, 16'h0AB5);
        drive(1'b0, 12'h000, 3'd0); tick();
        check("idle_valid", out_valid, 0);

        // Backpressure
        drive(1'b1, 12'hA5C, 3'd0); tick();
        check("bp_first", out_imm, 16'h0005);
        out_ready = 1'b0;
        drive(1'b1, 12'h0F8, 3'd4);
        #1;
        check("bp_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_imm", out_imm, 16'h0005);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        check("bp_new_imm", out_imm, 16'h00F8);
        check("bp_new_valid", out_valid, 1);
        drive(1'b0, 12'h000, 3'd0); tick();
        check("bp_drain", out_valid, 0);

        // Illegal modes
        drive(1'b1, 12'hFFF, 3'd6); tick();
        check("ill_imm", out_imm, 16'h0000);
        check("ill_err", out_err, 1);
        check("ill_valid", out_valid, 1);
        drive(1'b1, 12'h123, 3'd5); tick();
        check("ill_pfx_set", pfx_pending, 1);
        drive(1'b1, 12'hFFF, 3'd7); tick();
        check("ill_pfx_clear", pfx_pending, 0);
        check("ill7_err", out_err, 1);
        check("ill7_imm", out_imm, 16'h0000);
        drive(1'b1, 12'h007, 3'd1); tick();
        check("post_ill_imm", out_imm, 16'h0007);
        check("post_ill_err", out_err, 0);

        // Asynchronous reset mid-cycle with prefix pending
        drive(1'b1, 12'h123, 3'd5); tick();
        check("arst_pfx_before", pfx_pending, 1);
        drive(1'b0, 12'h000, 3'd0);
        #1 rst = 1'b1;
        #1;
        check("arst_pfx", pfx_pending, 0);
        check("arst_in_ready", in_ready, 1);
        tick();
        rst = 1'b0;

        // Asynchronous reset mid-cycle with output valid
        drive(1'b1, 12'h0F8, 3'd2); tick();
        check("arst_valid_before", out_valid, 1);
        drive(1'b0, 12'h000, 3'd0);
        #1 rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_imm", out_imm, 16'h0000);
        check("arst_err", out_err, 0);
        tick();
        rst = 1'b0;
        drive(1'b1, 12'h007, 3'd1); tick();
        check("post_rst_imm", out_imm, 16'h0007);

        // Flush drops the same-cycle input and the output register
        drive(1'b1, 12'h0F8, 3'd4); tick();
        check("fl_before", out_valid, 1);
        drive(1'b1, 12'h0AB, 3'd2);
        flush = 1'b1;
        tick();
        check("fl_valid", out_valid, 0);
        flush = 1'b0;
        drive(1'b0, 12'h000, 3'd0); tick();
        check("fl_dropped", out_valid, 0);

        // Flush clears a pending prefix
        drive(1'b1, 12'h123, 3'd5); tick();
        check("fl_pfx_set", pfx_pending, 1);
        drive(1'b0, 12'h000, 3'd0);
        flush = 1'b1;
        tick();
        check("fl_pfx_clear", pfx_pending, 0);
        flush = 1'b0;
        drive(1'b1, 12'h007, 3'd1); tick();
        check("fl_post_imm", out_imm, 16'h0007);
        drive(1'b0, 12'h000, 3'd0); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
